// File: rtl/div_iter_unit_pkg.sv
// rtl/div_iter_unit_pkg.sv - shared types for the iterative divider
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter_unit_if.sv
// rtl/div_iter_unit_if.sv - request/response handshake bundle of the divider
interface div_iter_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            op_signed;
  logic            op_rem;
  logic            op_word;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, dividend, divisor, op_signed, op_rem, op_word, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, op_signed, op_rem, op_word, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/div_iter_unit_step.sv
// rtl/div_iter_unit_step.sv - one combinational restoring-division step
module div_iter_unit_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN:0]   dvs,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);
  logic [XLEN:0] shifted;
  logic          take;

  // The partial remainder stays below the divisor, so rem[XLEN] is always
  // clear; folding it into the compare keeps the guard bit architecturally live.
  always_comb begin
    shifted  = {rem[XLEN-1:0], quo[XLEN-1]};
    take     = rem[XLEN] | (shifted >= dvs);
    rem_next = take ? (shifted - dvs) : shifted;
    quo_next = {quo[XLEN-2:0], take};
  end
endmodule

// File: rtl/div_iter_unit.sv
// rtl/div_iter_unit.sv - iterative restoring divider for the RV64M DIV/REM family
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  div_iter_unit_if.slave bus
);
  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN / BITS_PER_CYCLE + 1);

  div_state_e state, state_nxt;

  logic [XLEN:0]    rem_q, dvs_q;
  logic [XLEN-1:0]  quo_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, sel_rem_q, word_q;

  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
  logic [XLEN-1:0] special_raw, special_res, fix_q, fix_r, fix_res;
  logic            a_neg, b_neg, div_zero, overflow, special, accept;

  logic [XLEN:0]   rem_chain [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_chain [BITS_PER_CYCLE+1];

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic word);
    return word ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  always_comb begin
    a_ext   = bus.dividend;
    b_ext   = bus.divisor;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (bus.op_word) begin
      a_ext   = {{HALF{bus.op_signed & bus.dividend[HALF-1]}}, bus.dividend[HALF-1:0]};
      b_ext   = {{HALF{bus.op_signed & bus.divisor[HALF-1]}}, bus.divisor[HALF-1:0]};
      min_val = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};
    end
    a_neg    = bus.op_signed & a_ext[XLEN-1];
    b_neg    = bus.op_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = bus.op_signed & (a_ext == min_val) & (b_ext == '1);
    special  = div_zero | overflow;
    if (div_zero) special_raw = bus.op_rem ? a_ext : '1;
    else          special_raw = bus.op_rem ? '0 : a_ext;
    special_res = word_ext(special_raw, bus.op_word);
  end

  assign accept        = (state == DIV_IDLE) & bus.in_valid & ~bus.flush;
  assign bus.in_ready  = (state == DIV_IDLE);
  assign bus.out_valid = (state == DIV_DONE);
  assign bus.busy      = (state != DIV_IDLE);
  assign bus.result    = result_q;

  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_iter_unit_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_chain[i]),
      .quo      (quo_chain[i]),
      .dvs      (dvs_q),
      .rem_next (rem_chain[i+1]),
      .quo_next (quo_chain[i+1])
    );
  end

  always_comb begin
    fix_q   = q_neg_q ? -quo_q : quo_q;
    fix_r   = r_neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    fix_res = word_ext(sel_rem_q ? fix_r : fix_q, word_q);
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (bus.in_valid) state_nxt = special ? DIV_DONE : DIV_CALC;
        DIV_CALC: if (cnt_q == CNT_W'(1)) state_nxt = DIV_FIX;
        DIV_FIX:  state_nxt = DIV_DONE;
        DIV_DONE: if (bus.out_ready) state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nxt;
  end

  // W operands sit in the top half of quo so that after HALF shifts the
  // quotient lands in the low half and the upper half is already zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      word_q    <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      rem_q     <= '0;
      dvs_q     <= {1'b0, b_mag};
      quo_q     <= bus.op_word ? (a_mag << HALF) : a_mag;
      cnt_q     <= bus.op_word ? CNT_W'(HALF / BITS_PER_CYCLE) : CNT_W'(XLEN / BITS_PER_CYCLE);
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
      sel_rem_q <= bus.op_rem;
      word_q    <= bus.op_word;
      if (special) result_q <= special_res;
    end else if (state == DIV_CALC && !bus.flush) begin
      rem_q <= rem_chain[BITS_PER_CYCLE];
      quo_q <= quo_chain[BITS_PER_CYCLE];
      cnt_q <= cnt_q - 1'b1;
    end else if (state == DIV_FIX && !bus.flush) begin
      result_q <= fix_res;
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb/tb_div_iter_unit.sv - self-checking bench driving BITS_PER_CYCLE = 1, 2, 4 in lockstep
module tb_div_iter_unit;
  localparam int XLEN = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, op_signed = 1'b0, op_rem = 1'b0, op_word = 1'b0;
  logic        flush = 1'b0, out_ready = 1'b0;
  logic [63:0] dividend = '0, divisor = '0;

  logic [2:0]  ov, ir, bsy;
  logic [63:0] res [3];

  int          n_pass = 0, n_total = 0;
  logic [63:0] got_res [3];
  int          got_lat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    div_iter_unit_if #(.XLEN(XLEN)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.dividend  = dividend;
    assign bus.divisor   = divisor;
    assign bus.op_signed = op_signed;
    assign bus.op_rem    = op_rem;
    assign bus.op_word   = op_word;
    assign bus.flush     = flush;
    assign bus.out_ready = out_ready;
    assign ov[g]  = bus.out_valid;
    assign ir[g]  = bus.in_ready;
    assign bsy[g] = bus.busy;
    assign res[g] = bus.result;
    div_iter_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Reference: RISC-V M-extension semantics via native SV arithmetic.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic r, input logic w);
    logic [31:0] a32, b32, r32;
    logic signed [31:0] sa32, sb32;
    logic signed [63:0] sa, sb;
    a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32; sa = a; sb = b;
    if (w) begin
      if (b32 == 32'h0)                                         r32 = r ? a32 : 32'hFFFF_FFFF;
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'h0 : a32;
      else if (s)                                               r32 = r ? sa32 % sb32 : sa32 / sb32;
      else                                                      r32 = r ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'h0) return r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    if (s && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF) return r ? 64'h0 : a;
    if (s) return r ? sa % sb : sa / sb;
    return r ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic w, input int g);
    logic sp;
    if (w) sp = (b[31:0] == 32'h0) || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    else   sp = (b == 64'h0) || (s && a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (sp) return 1;
    return ((w ? 32 : 64) >> g) + 2;
  endfunction

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return {32'($urandom), 32'($urandom)};
      1:       return 64'($urandom_range(0, 20));
      2:       return -64'($urandom_range(1, 20));
      3:       return MIN64;
      4:       return 64'hFFFF_FFFF_FFFF_FFFF;
      5:       return {32'($urandom), 32'h8000_0000};
      6:       return 64'h0;
      default: return {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
    endcase
  endfunction

  // Issues one request to all three units; called and returns at #1 after a posedge.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r, input logic w);
    bit seen [3];
    for (int g = 0; g < 3; g++) begin seen[g] = 1'b0; got_lat[g] = -1; got_res[g] = 'x; end
    dividend = a; divisor = b; op_signed = s; op_rem = r; op_word = w; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = {32'($urandom), 32'($urandom)}; divisor = {32'($urandom), 32'($urandom)};
    for (int cyc = 1; cyc <= 200; cyc++) begin
      for (int g = 0; g < 3; g++)
        if (!seen[g] && ov[g]) begin seen[g] = 1'b1; got_lat[g] = cyc; got_res[g] = res[g]; end
      if (seen[0] && seen[1] && seen[2]) break;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      n_total++;
      if (ov[g] !== 1'b0 || bsy[g] !== 1'b0 || res[g] !== 64'h0) begin
        $display("FAIL reset_state dut%0d: out_valid=%b busy=%b result=%h, want 0/0/0", g, ov[g], bsy[g], res[g]);
      end else n_pass++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (ir !== 3'b111) $display("FAIL reset_in_ready: got %b, want 111", ir);
    else n_pass++;
  endtask

  typedef struct packed {
    logic [63:0] a, b, exp;
    logic        s, r, w;
    logic [1:0]  kind;
  } dir_t;

  task automatic test_directed();
    dir_t t [12];
    int   el;
    t[0]  = {64'd100, 64'd7, 64'd14, 1'b0, 1'b0, 1'b0, 2'd1};
    t[1]  = {64'd100, 64'd7, 64'd2, 1'b0, 1'b1, 1'b0, 2'd1};
    t[2]  = {64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b1, 1'b0, 1'b0, 2'd1};
    t[3]  = {64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0, 2'd1};
    t[4]  = {64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0, 2'd1};
    t[5]  = {64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0, 1'b1, 2'd0};
    t[6]  = {64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 1'b1, 2'd0};
    t[7]  = {64'hDEAD_BEEF_0123_4567, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 2'd0};
    t[8]  = {64'h1234, 64'h0, 64'h1234, 1'b0, 1'b1, 1'b0, 2'd0};
    t[9]  = {64'd5, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 2'd0};
    t[10] = {MIN64, 64'hFFFF_FFFF_FFFF_FFFF, MIN64, 1'b1, 1'b0, 1'b0, 2'd0};
    t[11] = {64'h0000_0000_8000_0000, 64'd3, 64'h0000_0000_2AAA_AAAA, 1'b0, 1'b0, 1'b1, 2'd2};
    for (int i = 0; i < 12; i++) begin
      run_op(t[i].a, t[i].b, t[i].s, t[i].r, t[i].w);
      for (int g = 0; g < 3; g++) begin
        el = (t[i].kind == 2'd0) ? 1 : (((t[i].kind == 2'd1) ? 64 : 32) >> g) + 2;
        n_total++;
        if (got_res[g] !== t[i].exp) $display("FAIL directed%0d_result dut%0d: got %h, want %h", i, g, got_res[g], t[i].exp);
        else n_pass++;
        n_total++;
        if (got_lat[g] != el) $display("FAIL directed%0d_latency dut%0d: got %0d, want %0d", i, g, got_lat[g], el);
        else n_pass++;
      end
    end
  endtask

  task automatic check_followup(input string name);
    logic [63:0] a, b, e;
    a = 64'h0123_4567_89AB_CDEF; b = 64'd12345;
    e = ref_div(a, b, 1'b0, 1'b0, 1'b0);
    run_op(a, b, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      n_total++;
      if (got_res[g] !== e) $display("FAIL %s_followup dut%0d: got %h, want %h", name, g, got_res[g], e);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    bit rose;
    dividend = 64'hFFFF_0000_1234_5678; divisor = 64'd99; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++;
    if (ir !== 3'b111 || bsy !== 3'b000) $display("FAIL flush_idle: in_ready=%b busy=%b, want 111/000", ir, bsy);
    else n_pass++;
    rose = 1'b0;
    repeat (80) begin
      if (ov !== 3'b000) rose = 1'b1;
      @(posedge clk); #1;
    end
    n_total++;
    if (rose) $display("FAIL flush_no_output: out_valid rose after flush, want never");
    else n_pass++;
    check_followup("flush");
  endtask

  task automatic test_reset_mid();
    bit rose;
    dividend = 64'h7777_8888_9999_AAAA; divisor = 64'd5; op_signed = 1'b1; op_rem = 1'b1; op_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_total++;
    if (ov !== 3'b000 || ir !== 3'b111 || bsy !== 3'b000)
      $display("FAIL reset_mid_state: out_valid=%b in_ready=%b busy=%b, want 000/111/000", ov, ir, bsy);
    else n_pass++;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    rose = 1'b0;
    repeat (80) begin
      if (ov !== 3'b000) rose = 1'b1;
      @(posedge clk); #1;
    end
    n_total++;
    if (rose) $display("FAIL reset_mid_no_output: out_valid rose after reset, want never");
    else n_pass++;
    check_followup("reset_mid");
  endtask

  task automatic test_stall();
    bit ok;
    dividend = 64'd100; divisor = 64'd7; op_signed = 1'b0; op_rem = 1'b0; op_word = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 64'd1; divisor = 64'd1;
    for (int cyc = 0; cyc < 200 && ov !== 3'b111; cyc++) begin
      @(posedge clk); #1;
    end
    n_total++;
    if (ov !== 3'b111) $display("FAIL stall_reach_done: out_valid=%b, want 111", ov);
    else n_pass++;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int g = 0; g < 3; g++)
        if (res[g] !== 64'd14 || ov[g] !== 1'b1 || ir[g] !== 1'b0) begin
          ok = 1'b0;
          $display("FAIL stall_hold dut%0d cycle%0d: result=%h out_valid=%b in_ready=%b, want 000000000000000e/1/0",
                   g, c, res[g], ov[g], ir[g]);
        end
      @(posedge clk); #1;
    end
    n_total++;
    if (ok) n_pass++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_total++;
    if (ir !== 3'b111 || ov !== 3'b000) $display("FAIL stall_release: in_ready=%b out_valid=%b, want 111/000", ir, ov);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] a, b, e;
    logic        s, r, w;
    int          el;
    for (int i = 0; i < 60; i++) begin
      a = rnd_operand(); b = rnd_operand();
      s = 1'($urandom); r = 1'($urandom); w = 1'($urandom);
      e = ref_div(a, b, s, r, w);
      run_op(a, b, s, r, w);
      for (int g = 0; g < 3; g++) begin
        el = ref_lat(a, b, s, w, g);
        n_total++;
        if (got_res[g] !== e)
          $display("FAIL random%0d_result dut%0d a=%h b=%h s%b r%b w%b: got %h, want %h", i, g, a, b, s, r, w, got_res[g], e);
        else n_pass++;
        n_total++;
        if (got_lat[g] != el) $display("FAIL random%0d_latency dut%0d: got %0d, want %0d", i, g, got_lat[g], el);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid();
    test_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_iter_unit.md
Name:
div_iter_unit

Overview:
- Parametrised iterative restoring divider for the execute stage. Serves all eight RV64M divide/remainder ops: DIV, DIVU, REM, REMU and the W forms.
- Retires BITS_PER_CYCLE quotient bits per clock.
- Uses a valid/ready handshake on both input and output, supports pipeline flush, and applies RISC-V divide-by-zero and signed-overflow results without iterating.

Parameters:
- XLEN, 64, datapath width; W ops operate on XLEN/2.
- BITS_PER_CYCLE, 1, restoring steps per clock; must divide XLEN/2 (legal values 1, 2, 4).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; high only in IDLE.
- dividend  in  XLEN  numerator (rs1).
- divisor  in  XLEN  denominator (rs2).
- op_signed  in  1  1 = signed (DIV/REM[W]), 0 = unsigned.
- op_rem  in  1  1 = return remainder, 0 = return quotient.
- op_word  in  1  1 = W op: use low XLEN/2 bits, result sign-extended to XLEN.
- flush  in  1  abort current operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  quotient or remainder.
- busy  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE, out_valid=0, result=0, busy=0, all internal registers 0. in_ready=1 after reset release.
- States and transitions:
  - IDLE -> CALC on in_valid&in_ready for normal operands.
  - IDLE -> DONE on in_valid&in_ready for special cases.
  - CALC -> FIX when the iteration counter hits 0.
  - FIX -> DONE.
  - DONE -> IDLE on out_ready.
- Operands are captured only at accept; later input changes are ignored.
- Operand preparation at accept:
  - Working width W = op_word ? XLEN/2 : XLEN.
  - W-mode operands are sign-extended from bit W-1 when op_signed, else zero-extended.
  - When op_signed, operands are converted to magnitudes. Record q_neg = sign(dividend)^sign(divisor) and r_neg = sign(dividend).
- CALC:
  - Counter loaded with W/BITS_PER_CYCLE.
  - Each cycle performs BITS_PER_CYCLE restoring steps: shift {rem,quo} left 1; if rem >= |divisor|, subtract and set quo LSB to 1.
  - Counter decrements once per cycle.
- FIX: negate quotient if q_neg; negate remainder if r_neg. Select the quotient or remainder per op_rem. In W mode, sign-extend bit W-1 to XLEN for both signed and unsigned ops. Register the selection into result.
- Latency for normal operands: out_valid rises W/BITS_PER_CYCLE+2 cycles after the accept edge. With defaults this is 66 for 64-bit ops and 34 for W ops.
- Special cases resolve at accept; out_valid is high 1 cycle after the accept edge:
  - divisor==0 (in W width): quotient = all ones (W-extended), remainder = dividend (W-extended).
  - op_signed and dividend == most-negative and divisor == -1: quotient = dividend, remainder = 0.
- DONE: out_valid and result are held stable until out_ready. in_ready=0 in DONE, so no new request overlaps the handshake cycle.
- flush in any state: next state IDLE, out_valid=0, result discarded. flush has priority over in_valid and out_ready in the same cycle. flush in IDLE has no effect.
- An asynchronous reset mid-operation returns to IDLE with no output pulse.
- All arithmetic is unsigned on magnitudes of width XLEN+1 (guard bit for the compare/subtract). No truncation before FIX.

Decomposition:
- defines.v gets the state encodings (DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE) and the zero/all-ones word constants.
- Sub-module div_step: purely combinational single restoring step (partial remainder, divisor, quotient in -> shifted/updated out). Instantiated BITS_PER_CYCLE times via generate and chained.
- The FSM, counter, sign handling and special-case detection stay in div_iter_unit.

Test Plan:
- DIVU 64-bit, 100/7 -> result 14 at cycle 66 after accept; REMU same operands -> 2.
- DIV, -100/7 -> 0xFFFF_FFFF_FFFF_FFF2 (-14); REM, -100/7 -> -2; REM, 100/-7 -> 2.
- DIVW, 0x0000_0001_8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (overflow), 1 cycle after accept. REMW same -> 0.
- DIVU x/0 -> all ones, REMU 0x1234/0 -> 0x1234, both 1 cycle after accept; DIVUW 5/0 -> 0xFFFF_FFFF_FFFF_FFFF.
- Flush asserted in CALC cycle 10 -> out_valid never rises, in_ready=1 next cycle. A new request then completes with correct result. Repeat with rst pulsed low mid-CALC.
- out_ready held low 5 cycles in DONE -> result stable, in_ready=0. Sweep BITS_PER_CYCLE=2,4 with random signed/unsigned/W operands vs. a reference model; latency 34/18 for 64-bit ops.
